// File: rtl/sprite_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// sprite_frame_sequencer_if
//
// Purpose : valid/ready sprite stream between the game processor, the frame
//           sequencer and the graphics block. One beat carries one sprite.
//
// Signals : valid  - the master presents a sprite this cycle
//           ready  - the slave accepts it (transfer on valid && ready)
//           x      - sprite x position, XW bits
//           y      - sprite y position, YW bits
//           frame  - sprite frame index, FW bits
//           last   - final sprite of the master's batch for this video frame
//
// Modports: master drives valid/x/y/frame/last, slave drives ready.
// ----------------------------------------------------------------------------
interface sprite_frame_sequencer_if #(
    parameter int XW = 9,
    parameter int YW = 10,
    parameter int FW = 5
) ();
    logic          valid;
    logic          ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
    logic          last;

    modport master (output valid, x, y, frame, last, input  ready);
    modport slave  (input  valid, x, y, frame, last, output ready);
endinterface

// File: rtl/sprite_frame_sequencer.sv
// ----------------------------------------------------------------------------
// sprite_frame_sequencer
//
// Purpose : sole writer of the graphics sprite port. On every new_frame it
//           snapshots both mice, drains the processor's sprite stream up to
//           the per-frame budget, then appends one cursor sprite per enabled
//           player so the cursors are drawn on top. Frames that start before
//           the previous sequence finished are counted as overruns.
//
// Ports   : clk_in         pixel clock
//           rst_in         synchronous active-low reset
//           new_frame      one-cycle pulse at the start of each video frame
//           cursor_en      bit0 = player A cursor, bit1 = player B cursor
//           mouse_a_x/y    player A position, click_a player A button
//           mouse_b_x/y    player B position, click_b player B button
//           proc           slave stream from the processor (proc.ready out)
//           sprite         master stream to graphics (one-entry output reg)
//           busy           high in PROC, CUR_A and CUR_B
//           sprite_count   sprites issued this frame, cursors included
//           overrun_count  saturating count of overrun frames
// ----------------------------------------------------------------------------
module sprite_frame_sequencer #(
    parameter int CANVAS_WIDTH       = 360,
    parameter int CANVAS_HEIGHT      = 720,
    parameter int NUM_FRAMES         = 24,
    parameter int MAX_SPRITES        = 64,
    parameter int CURSOR_IDLE_FRAME  = 22,
    parameter int CURSOR_CLICK_FRAME = 23,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT),
    localparam int FW = $clog2(NUM_FRAMES)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        new_frame,
    input  logic [1:0]                  cursor_en,
    input  logic [XW-1:0]               mouse_a_x,
    input  logic [YW-1:0]               mouse_a_y,
    input  logic                        click_a,
    input  logic [XW-1:0]               mouse_b_x,
    input  logic [YW-1:0]               mouse_b_y,
    input  logic                        click_b,
    sprite_frame_sequencer_if.slave     proc,
    sprite_frame_sequencer_if.master    sprite,
    output logic                        busy,
    output logic [6:0]                  sprite_count,
    output logic [7:0]                  overrun_count
);

    localparam logic [XW-1:0] X_MAX = XW'(CANVAS_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(CANVAS_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, PROC, CUR_A, CUR_B, DONE} state_t;
    typedef enum logic [1:0] {LOAD_NONE, LOAD_PROC, LOAD_CUR_A, LOAD_CUR_B} load_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          click;
    } cursor_t;

    state_t        state, state_next, after_proc;
    load_t         load_sel;
    cursor_t       snap_a, snap_b, cur_sel;
    logic [1:0]    snap_en;
    logic [6:0]    budget;
    logic [6:0]    count_q;
    logic [7:0]    overrun_q;
    logic          slot_free;
    logic          proc_ready_c;
    logic          budget_hit;

    logic          out_valid_q;
    logic [XW-1:0] out_x_q, load_x;
    logic [YW-1:0] out_y_q, load_y;
    logic [FW-1:0] out_frame_q, load_frame;

    // The output register can take a new sprite when empty or draining now.
    assign slot_free  = !out_valid_q || sprite.ready;
    assign budget     = 7'(MAX_SPRITES) - {6'd0, snap_en[0]} - {6'd0, snap_en[1]};
    // True when the sprite being accepted is the last one the budget allows.
    assign budget_hit = (count_q + 7'd1) >= budget;

    // First enabled cursor after the processor stream, or straight to DONE.
    assign after_proc = snap_en[0] ? CUR_A : (snap_en[1] ? CUR_B : DONE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in this block samples pre-edge values.
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next; without it
        // the unlisted cases would infer a latch.
        state_next = state;
        case (state)
            PROC:    if (load_sel == LOAD_PROC && (proc.last || budget_hit))
                         state_next = after_proc;
            CUR_A:   if (slot_free) state_next = snap_en[1] ? CUR_B : DONE;
            CUR_B:   if (slot_free) state_next = DONE;
            default: ;
        endcase
        // A new frame always restarts the sequence; any load selected this
        // cycle still completes and belongs to the old frame.
        if (new_frame) state_next = PROC;
    end

    // ------------------------------------------------------------------------
    // Output logic: status, processor ready and which sprite to load
    // ------------------------------------------------------------------------
    always_comb begin
        busy         = (state == PROC) || (state == CUR_A) || (state == CUR_B);
        // Depends on state and registers only, never on proc.valid.
        proc_ready_c = (state == PROC) && slot_free && (count_q < budget);
        load_sel     = LOAD_NONE;
        case (state)
            PROC:    if (proc.valid && proc_ready_c) load_sel = LOAD_PROC;
            CUR_A:   if (slot_free) load_sel = LOAD_CUR_A;
            CUR_B:   if (slot_free) load_sel = LOAD_CUR_B;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load data mux: processor sprite or clamped cursor from the snapshot
    // ------------------------------------------------------------------------
    always_comb begin
        cur_sel    = (load_sel == LOAD_CUR_B) ? snap_b : snap_a;
        load_x     = proc.x;
        load_y     = proc.y;
        load_frame = proc.frame;
        if (load_sel == LOAD_CUR_A || load_sel == LOAD_CUR_B) begin
            load_x     = (cur_sel.x > X_MAX) ? X_MAX : cur_sel.x;
            load_y     = (cur_sel.y > Y_MAX) ? Y_MAX : cur_sel.y;
            load_frame = cur_sel.click ? FW'(CURSOR_CLICK_FRAME)
                                       : FW'(CURSOR_IDLE_FRAME);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: snapshot, output register, counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: the snapshot and output data registers are reset as well, so
        // sprite_* read 0 straight out of reset and a pending sprite is lost.
        if (!rst_in) begin
            snap_a      <= '0;
            snap_b      <= '0;
            snap_en     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_frame_q <= '0;
            count_q     <= '0;
            overrun_q   <= '0;
        end else begin
            if (new_frame) begin
                snap_a  <= '{x: mouse_a_x, y: mouse_a_y, click: click_a};
                snap_b  <= '{x: mouse_b_x, y: mouse_b_y, click: click_b};
                snap_en <= cursor_en;
            end

            // Loads only happen when the slot is free, so a stalled sprite
            // is never overwritten or retracted.
            if (load_sel != LOAD_NONE) begin
                out_valid_q <= 1'b1;
                out_x_q     <= load_x;
                out_y_q     <= load_y;
                out_frame_q <= load_frame;
            end else if (sprite.ready) begin
                out_valid_q <= 1'b0;
            end

            if (new_frame) begin
                count_q <= '0;
            end else if (load_sel != LOAD_NONE) begin
                count_q <= count_q + 7'd1;
            end

            if (new_frame && busy && overrun_q != 8'hFF) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign proc.ready    = proc_ready_c;
    assign sprite.valid  = out_valid_q;
    assign sprite.x      = out_x_q;
    assign sprite.y      = out_y_q;
    assign sprite.frame  = out_frame_q;
    assign sprite.last   = 1'b0;   // no batch marker on the graphics side
    assign sprite_count  = count_q;
    assign overrun_count = overrun_q;

endmodule

// File: doc/sprite_frame_sequencer.md
Name: sprite_frame_sequencer

Overview:
- Sole writer to the graphics sprite input port (sprite_valid/x/y/frame).
- Each video frame it drains the game processor's sprite stream, then appends one cursor sprite per enabled player so cursors draw on top.
- Sits between singleprocessor, the two mouse_iface outputs (already in the pixel domain) and graphics.
- Also enforces the per-frame sprite budget and reports frame overruns.

Parameters:
- CANVAS_WIDTH, 360, canvas width in pixels; x fields are $clog2(CANVAS_WIDTH) bits (XW).
- CANVAS_HEIGHT, 720, canvas height in pixels; y fields are $clog2(CANVAS_HEIGHT) bits (YW).
- NUM_FRAMES, 24, sprite frame count; frame fields are $clog2(NUM_FRAMES) bits (FW).
- MAX_SPRITES, 64, total sprites emitted per video frame, cursors included.
- CURSOR_IDLE_FRAME, 22, frame index for a cursor whose button is not pressed.
- CURSOR_CLICK_FRAME, 23, frame index for a cursor whose button is pressed.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  synchronous, active-low reset.
- new_frame  in  1  one-cycle pulse at the start of each frame.
- cursor_en  in  2  bit0 enables player A's cursor; bit1 enables player B's cursor.
- mouse_a_x  in  XW  player A x position. mouse_a_y  in  YW  player A y position. click_a  in  1  player A button.
- mouse_b_x  in  XW  player B x position. mouse_b_y  in  YW  player B y position. click_b  in  1  player B button.
- proc_valid  in  1  processor has a sprite. proc_x  in  XW. proc_y  in  YW. proc_frame  in  FW. proc_last  in  1  marks the processor's final sprite for this frame.
- proc_ready  out  1  the sequencer accepts the processor sprite this cycle.
- sprite_ready  in  1  graphics accepts the presented sprite.
- sprite_valid  out  1. sprite_x  out  XW. sprite_y  out  YW. sprite_frame  out  FW.
- busy  out  1  a frame sequence is in progress.
- sprite_count  out  7  sprites issued this frame.
- overrun_count  out  8  saturating count of frames that started before the previous sequence finished.

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - All outputs go to 0 and the state goes to IDLE.
  - The snapshot registers are cleared.
  - This applies mid-sequence too, and any presented sprite is dropped.
- States: IDLE, PROC, CUR_A, CUR_B, DONE. busy=1 in PROC, CUR_A and CUR_B.
- new_frame in IDLE or DONE:
  - Snapshot all mouse/click inputs and cursor_en. The snapshot is held until the next new_frame.
  - Clear sprite_count.
  - Compute budget = MAX_SPRITES − popcount(cursor_en snapshot).
  - Go to PROC.
- new_frame in PROC, CUR_A or CUR_B:
  - overrun_count increments, saturating at 255.
  - Same restart actions as from IDLE, and the sequence restarts in PROC.
  - A sprite already presented stays valid and stable until accepted; it is never retracted.
- Output register (one-entry):
  - A slot is free when sprite_valid==0 or sprite_ready==1.
  - sprite_* must not change while sprite_valid&&!sprite_ready.
  - sprite_valid drops the cycle after the final handshake when nothing new is loaded.
- PROC:
  - proc_ready = (state==PROC) && slot free && sprite_count<budget. It is combinational from state and registers only, not from proc_valid.
  - On proc_valid&&proc_ready: the sprite appears on sprite_* with sprite_valid=1 at the next edge (latency 1) and sprite_count increments.
  - Exit to the first enabled cursor state, then DONE, on either of: (a) accepting a sprite with proc_last=1; (b) sprite_count reaching budget.
  - On exit through the budget (b), the remaining processor sprites are left unaccepted; they are not an error.
- CUR_A / CUR_B:
  - When the slot is free, load the cursor sprite and move to the next enabled cursor state, or to DONE.
  - Cursor x/y come from the snapshot, clamped to CANVAS_WIDTH−1 and CANVAS_HEIGHT−1.
  - Cursor frame is CURSOR_CLICK_FRAME if click=1, else CURSOR_IDLE_FRAME.
  - Disabled cursors are skipped with no cycle spent.
- DONE:
  - Wait for new_frame.
  - proc_ready=0 and no new loads; the last sprite drains normally.
- new_frame coinciding with a handshake:
  - The handshake completes first and that sprite is counted in the old frame.
  - sprite_count is then cleared.
- Arithmetic:
  - sprite_count is 7 bits and never exceeds MAX_SPRITES.
  - Comparisons against budget are unsigned.

Test Plan:
- Reset held low, then released:
  - All outputs are 0 and the state is IDLE.
  - proc_ready stays 0 until the first new_frame.
- cursor_en=2'b11, processor streams 3 sprites with proc_last on the 3rd, sprite_ready always 1:
  - 5 sprites issued in order P0,P1,P2, cursor A, cursor B; sprite_count=5.
  - busy falls the cycle after cursor B loads.
- Mouse A at (400,800) with click_a=1, cursor_en=2'b01:
  - Cursor sprite is x=359, y=719, frame=23.
  - Mouse inputs changed mid-frame do not alter it.
- Processor streams 70 sprites with no proc_last, cursor_en=2'b11:
  - Exactly 62 processor sprites are accepted, then proc_ready=0.
  - 2 cursors follow; sprite_count=64.
- sprite_ready held 0 for 5 cycles with sprite_valid=1:
  - sprite_* are stable throughout and proc_ready=0.
  - On release the sprite is accepted once, with no duplicate and no loss.
- new_frame pulsed while in PROC after 10 sprites:
  - overrun_count becomes 1 and sprite_count restarts from 0.
  - The pending sprite is delivered intact.
  - 300 such overruns saturate overrun_count at 255.
